// File: rtl/score_counter_mc.sv
// Multi-channel edge-triggered score counter with saturate or wrap limits.
// Each channel counts on rising edges of en_i; clear and load are shared strobes.
module score_counter_mc #(
  parameter int BW      = 7,
  parameter int MAX_VAL = 99,
  parameter int N_CH    = 2,
  parameter int WRAP    = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [N_CH-1:0]   en_i,
  input  logic [N_CH-1:0]   mod_i,
  input  logic [BW-1:0]     step_i,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [N_CH-1:0]   load_ch_i,
  input  logic [BW-1:0]     load_val_i,
  output logic [N_CH*BW-1:0] counter_val_o,
  output logic [N_CH-1:0]   at_max_o,
  output logic [N_CH-1:0]   at_min_o,
  output logic [N_CH-1:0]   lim_o
);

  localparam logic [BW:0] LIM_MAX = (BW+1)'(MAX_VAL);
  localparam logic [BW:0] MODULUS = (BW+1)'(MAX_VAL + 1);

  logic [N_CH-1:0] r_en_d;
  logic [N_CH-1:0] w_evt;
  logic [BW:0]     w_step;
  logic [BW-1:0]   w_load;

  assign w_evt  = en_i & ~r_en_d;
  assign w_step = ({1'b0, step_i} > LIM_MAX) ? LIM_MAX : {1'b0, step_i};
  assign w_load = ({1'b0, load_val_i} > LIM_MAX) ? LIM_MAX[BW-1:0] : load_val_i;

  // History tracks en_i unconditionally, so edges under clear/load are consumed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_en_d <= '0;
    else         r_en_d <= en_i;
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [BW-1:0] r_val;
    logic          r_lim;
    logic [BW:0]   w_val;
    logic [BW:0]   w_sum;
    logic [BW-1:0] w_res;
    logic          w_over;

    always_comb begin
      w_val  = {1'b0, r_val};
      w_sum  = w_val + w_step;
      w_res  = r_val;
      w_over = 1'b0;
      if (mod_i[c]) begin
        if (w_sum > LIM_MAX) begin
          w_over = 1'b1;
          w_res  = (WRAP != 0) ? BW'(w_sum - MODULUS) : LIM_MAX[BW-1:0];
        end else begin
          w_res = BW'(w_sum);
        end
      end else begin
        if (w_step > w_val) begin
          w_over = 1'b1;
          w_res  = (WRAP != 0) ? BW'(w_val + MODULUS - w_step) : '0;
        end else begin
          w_res = BW'(w_val - w_step);
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_val <= '0;
        r_lim <= 1'b0;
      end else if (clr_i) begin
        r_val <= '0;
        r_lim <= 1'b0;
      end else if (load_i && load_ch_i[c]) begin
        r_val <= w_load;
        r_lim <= 1'b0;
      end else if (w_evt[c]) begin
        r_val <= w_res;
        r_lim <= w_over;
      end else begin
        r_lim <= 1'b0;
      end
    end

    assign counter_val_o[c*BW +: BW] = r_val;
    assign at_max_o[c] = (r_val == LIM_MAX[BW-1:0]);
    assign at_min_o[c] = (r_val == '0);
    assign lim_o[c]    = r_lim;
  end

endmodule

// File: tb/tb_score_counter_mc.sv
// Bench for score_counter_mc: a saturating and a wrapping instance share stimulus;
// vectors carry hand-derived expectations through a scoreboard queue.
module tb_score_counter_mc;
  localparam int W = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  en, mod, ld_ch;
  logic [6:0]  step, ld_val;
  logic        clr, load;
  logic [13:0] cv0, cv1;
  logic [1:0]  amax0, amin0, lim0, amax1, amin1, lim1;

  int n_cmp = 0;
  int n_err = 0;
  logic [W:0] exp_q[$];

  typedef struct {
    bit         sel;
    logic [1:0] en, mod, ld_ch;
    logic [6:0] step, ld_val;
    logic       clr, load;
    logic [W-1:0] exp;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  score_counter_mc #(.BW(7), .MAX_VAL(99), .N_CH(2), .WRAP(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .mod_i(mod), .step_i(step),
    .clr_i(clr), .load_i(load), .load_ch_i(ld_ch), .load_val_i(ld_val),
    .counter_val_o(cv0), .at_max_o(amax0), .at_min_o(amin0), .lim_o(lim0)
  );

  score_counter_mc #(.BW(7), .MAX_VAL(99), .N_CH(2), .WRAP(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .mod_i(mod), .step_i(step),
    .clr_i(clr), .load_i(load), .load_ch_i(ld_ch), .load_val_i(ld_val),
    .counter_val_o(cv1), .at_max_o(amax1), .at_min_o(amin1), .lim_o(lim1)
  );

  function automatic logic [W-1:0] act_of(bit sel);
    return sel ? {cv1, amax1, amin1, lim1} : {cv0, amax0, amin0, lim0};
  endfunction

  function automatic logic [W-1:0] pack_exp(int e1, int e0, int emax, int emin, int elim);
    return {7'(e1), 7'(e0), 2'(emax), 2'(emin), 2'(elim)};
  endfunction

  // Args: dut sel, en, mod, step, clr, load, load_ch, load_val, then ch1, ch0, max, min, lim.
  function automatic vec_t mk(int sel, int e, int m, int s, int c, int l, int lc, int lv,
                              int e1, int e0, int emax, int emin, int elim);
    vec_t v;
    v.sel = 1'(sel); v.en = 2'(e); v.mod = 2'(m); v.step = 7'(s);
    v.clr = 1'(c); v.load = 1'(l); v.ld_ch = 2'(lc); v.ld_val = 7'(lv);
    v.exp = pack_exp(e1, e0, emax, emin, elim);
    return v;
  endfunction

  task automatic drive(vec_t v);
    en = v.en; mod = v.mod; step = v.step; clr = v.clr;
    load = v.load; ld_ch = v.ld_ch; ld_val = v.ld_val;
  endtask

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pop_check(string name);
    logic [W:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s: got empty queue expected an entry", name);
    end else begin
      e = exp_q.pop_front();
      check(name, act_of(e[W]), e[W-1:0]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en = '0; mod = '0; step = '0; clr = 1'b0; load = 1'b0; ld_ch = '0; ld_val = '0;
    #1;
    exp_q.push_back({1'b0, pack_exp(0, 0, 0, 3, 0)});
    pop_check("reset_dut0");
    exp_q.push_back({1'b1, pack_exp(0, 0, 0, 3, 0)});
    pop_check("reset_dut1");

    // single edge while held
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 1, 3, 1, 0, 0, 0, 0, 0, 1, 0, 2, 0));
    vecs.push_back(mk(0, 0, 3, 1, 0, 0, 0, 0, 0, 1, 0, 2, 0));
    // saturate at top
    vecs.push_back(mk(0, 0, 3, 1, 0, 1, 1, 97, 0, 97, 0, 2, 0));
    vecs.push_back(mk(0, 1, 3, 1, 0, 0, 0, 0, 0, 98, 0, 2, 0));
    vecs.push_back(mk(0, 0, 3, 1, 0, 0, 0, 0, 0, 98, 0, 2, 0));
    vecs.push_back(mk(0, 1, 3, 1, 0, 0, 0, 0, 0, 99, 1, 2, 0));
    vecs.push_back(mk(0, 0, 3, 1, 0, 0, 0, 0, 0, 99, 1, 2, 0));
    vecs.push_back(mk(0, 1, 3, 1, 0, 0, 0, 0, 0, 99, 1, 2, 1));
    vecs.push_back(mk(0, 0, 3, 1, 0, 0, 0, 0, 0, 99, 1, 2, 0));
    // load clamp on ch1 while ch0 counts
    vecs.push_back(mk(0, 0, 3, 1, 0, 1, 1, 10, 0, 10, 0, 2, 0));
    vecs.push_back(mk(0, 1, 3, 4, 0, 1, 2, 120, 99, 14, 2, 0, 0));
    vecs.push_back(mk(0, 0, 3, 4, 0, 0, 0, 0, 99, 14, 2, 0, 0));
    // down saturate, oversized step clamps
    vecs.push_back(mk(0, 1, 0, 20, 0, 0, 0, 0, 99, 0, 2, 1, 1));
    vecs.push_back(mk(0, 0, 0, 20, 0, 0, 0, 0, 99, 0, 2, 1, 0));
    vecs.push_back(mk(0, 2, 0, 127, 0, 0, 0, 0, 0, 0, 0, 3, 0));
    vecs.push_back(mk(0, 0, 0, 127, 0, 0, 0, 0, 0, 0, 0, 3, 0));
    vecs.push_back(mk(0, 1, 1, 127, 0, 0, 0, 0, 0, 99, 1, 2, 0));
    vecs.push_back(mk(0, 0, 1, 127, 0, 0, 0, 0, 0, 99, 1, 2, 0));
    // zero step, then both channels hit limits together
    vecs.push_back(mk(0, 3, 3, 0, 0, 0, 0, 0, 0, 99, 1, 2, 0));
    vecs.push_back(mk(0, 0, 3, 0, 0, 0, 0, 0, 0, 99, 1, 2, 0));
    vecs.push_back(mk(0, 3, 1, 1, 0, 0, 0, 0, 0, 99, 1, 2, 3));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 99, 1, 2, 0));
    vecs.push_back(mk(0, 3, 2, 5, 0, 0, 0, 0, 5, 94, 0, 0, 0));
    vecs.push_back(mk(0, 0, 2, 5, 0, 0, 0, 0, 5, 94, 0, 0, 0));
    // clear beats load beats count; held en must not count later
    vecs.push_back(mk(0, 3, 3, 1, 1, 1, 3, 50, 0, 0, 0, 3, 0));
    vecs.push_back(mk(0, 3, 3, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0));
    vecs.push_back(mk(0, 3, 3, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0));
    vecs.push_back(mk(0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0));
    vecs.push_back(mk(0, 3, 3, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3, 1, 0, 1, 1, 99, 1, 99, 1, 0, 0));
    vecs.push_back(mk(0, 0, 3, 1, 0, 0, 0, 0, 1, 99, 1, 0, 0));
    vecs.push_back(mk(0, 2, 0, 1, 0, 0, 0, 0, 0, 99, 1, 2, 0));
    // wrapping instance
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 2, 0, 2, 0, 2, 0));
    vecs.push_back(mk(1, 1, 0, 5, 0, 0, 0, 0, 0, 97, 0, 2, 1));
    vecs.push_back(mk(1, 0, 0, 5, 0, 0, 0, 0, 0, 97, 0, 2, 0));
    vecs.push_back(mk(1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 3, 1));
    vecs.push_back(mk(1, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 3, 0));
    vecs.push_back(mk(1, 2, 2, 127, 0, 0, 0, 0, 99, 0, 2, 1, 0));
    vecs.push_back(mk(1, 0, 2, 127, 0, 0, 0, 0, 99, 0, 2, 1, 0));
    vecs.push_back(mk(1, 2, 2, 1, 0, 0, 0, 0, 0, 0, 0, 3, 2));
    vecs.push_back(mk(1, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0));

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      exp_q.push_back({vecs[i].sel, vecs[i].exp});
      @(posedge clk);
      @(negedge clk);
      pop_check($sformatf("vec%0d", i));
    end

    // asynchronous reset mid-cycle with nonzero values
    drive(mk(0, 0, 3, 1, 0, 1, 3, 40, 0, 0, 0, 0, 0));
    exp_q.push_back({1'b0, pack_exp(40, 40, 0, 0, 0)});
    @(posedge clk);
    @(negedge clk);
    pop_check("preload");
    drive(mk(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2 rst_n = 1'b0;
    #1;
    exp_q.push_back({1'b0, pack_exp(0, 0, 0, 3, 0)});
    pop_check("async_rst_dut0");
    exp_q.push_back({1'b1, pack_exp(0, 0, 0, 3, 0)});
    pop_check("async_rst_dut1");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    exp_q.push_back({1'b0, pack_exp(0, 1, 0, 2, 0)});
    pop_check("release_count_dut0");
    exp_q.push_back({1'b1, pack_exp(0, 1, 0, 2, 0)});
    pop_check("release_count_dut1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
